// File: rtl/async_fill_trig_scheduler_if.sv
// Fill-control bus between the ASYNC acquisition sequencer (master) and the
// per-fill trigger scheduler (slave). drain_timeout exists only when
// ASYNC_SCHED_DRAIN_TIMEOUT_EN is defined.
interface async_fill_trig_scheduler_if;
  logic        fill_start;
  logic [23:0] fill_window_len;
  logic [10:0] async_num_bursts;
  logic [15:0] max_waveforms;
  logic        raw_trig;
  logic [15:0] circ_buf_wr_addr;
  logic        trig_fifo_full;
  logic        trig_fifo_empty;
  logic        cbuf_rd_trig_wait;
  logic        cbuf_trig_en;
  logic        cbuf_rd_en;
  logic        trig_fifo_wr_en;
  logic [15:0] trig_fifo_wr_dat;
  logic        fill_busy;
  logic        fill_done;
  logic [15:0] accepted_count;
  logic [15:0] dropped_count;
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
  logic        drain_timeout;
`endif

  modport master (
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
    input  drain_timeout,
`endif
    output fill_start, fill_window_len, async_num_bursts, max_waveforms,
           raw_trig, circ_buf_wr_addr, trig_fifo_full, trig_fifo_empty,
           cbuf_rd_trig_wait,
    input  cbuf_trig_en, cbuf_rd_en, trig_fifo_wr_en, trig_fifo_wr_dat,
           fill_busy, fill_done, accepted_count, dropped_count
  );

  modport slave (
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
    output drain_timeout,
`endif
    input  fill_start, fill_window_len, async_num_bursts, max_waveforms,
           raw_trig, circ_buf_wr_addr, trig_fifo_full, trig_fifo_empty,
           cbuf_rd_trig_wait,
    output cbuf_trig_en, cbuf_rd_en, trig_fifo_wr_en, trig_fifo_wr_dat,
           fill_busy, fill_done, accepted_count, dropped_count
  );
endinterface

// File: rtl/async_fill_trig_scheduler.sv
// Per-fill ASYNC trigger scheduler (adc_clk domain): trigger window,
// edge qualification, trigger FIFO writes, drain/close sequencing.
// Optional macro ASYNC_SCHED_DRAIN_TIMEOUT_EN bounds DRAIN to DRAIN_TIMEOUT
// cycles and adds the sticky drain_timeout flag.
module async_fill_trig_scheduler #(
  parameter int unsigned CLOSE_CYCLES  = 16,
  parameter int unsigned DRAIN_TIMEOUT = 65535
) (
  input  logic                          adc_clk,
  input  logic                          reset_clk_adc,
  async_fill_trig_scheduler_if.slave    bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_CLOSE = 2'd3;

  localparam int unsigned CW = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;
  localparam logic [CW-1:0] CLOSE_LAST = CW'(CLOSE_CYCLES - 1);

  if (CLOSE_CYCLES == 0 || DRAIN_TIMEOUT == 0 || DRAIN_TIMEOUT > 65536) begin : g_bad_params
    $error("async_fill_trig_scheduler: CLOSE_CYCLES/DRAIN_TIMEOUT out of range");
  end

  logic [1:0]    state_q, state_d;
  logic [23:0]   win_q, win_d;
  logic [12:0]   holdoff_q, holdoff_d;
  logic          raw_trig_dly_q, raw_trig_dly_d;
  logic [15:0]   acc_q, acc_d;
  logic [15:0]   drop_q, drop_d;
  logic          wr_en_q, wr_en_d;
  logic [15:0]   wr_dat_q, wr_dat_d;
  logic          trig_en_q, trig_en_d;
  logic          rd_en_q, rd_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] close_q, close_d;
  logic          trig_edge;
  logic          accept;
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);
  logic [15:0]   drain_cnt_q, drain_cnt_d;
  logic          dto_q, dto_d;
`endif

  assign trig_edge = bus.raw_trig & ~raw_trig_dly_q;
  assign accept    = (holdoff_q == '0) && !bus.trig_fifo_full &&
                     ((bus.max_waveforms == '0) || (acc_q < bus.max_waveforms));

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d        = state_q;
    win_d          = win_q;
    holdoff_d      = (holdoff_q != '0) ? holdoff_q - 13'd1 : '0;
    raw_trig_dly_d = bus.raw_trig;
    acc_d          = acc_q;
    drop_d         = drop_q;
    wr_en_d        = 1'b0;
    wr_dat_d       = wr_dat_q;
    done_d         = 1'b0;
    close_d        = close_q;
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
    drain_cnt_d    = (state_q == ST_DRAIN) ? drain_cnt_q + 16'd1 : '0;
    dto_d          = dto_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.fill_start) begin
          acc_d     = '0;
          drop_d    = '0;
          holdoff_d = '0;
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
          dto_d     = 1'b0;
`endif
          if (bus.fill_window_len == '0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ARMED;
            win_d   = bus.fill_window_len;
          end
        end
      end
      ST_ARMED: begin
        win_d = win_q - 24'd1;
        if (win_q == 24'd1) state_d = ST_DRAIN;
        if (trig_edge) begin
          if (accept) begin
            wr_en_d   = 1'b1;
            wr_dat_d  = bus.circ_buf_wr_addr;
            holdoff_d = {bus.async_num_bursts, 2'b00};
            if (acc_q != '1) acc_d = acc_q + 16'd1;
          end else if (drop_q != '1) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.trig_fifo_empty && bus.cbuf_rd_trig_wait && !wr_en_q) begin
          state_d = ST_CLOSE;
          close_d = '0;
        end
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
        else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_CLOSE;
          close_d = '0;
          dto_d   = 1'b1;
        end
`endif
      end
      default: begin
        if (close_q == CLOSE_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          close_d = close_q + 1'b1;
        end
      end
    endcase
    trig_en_d = (state_d == ST_ARMED);
    rd_en_d   = (state_d == ST_ARMED) || (state_d == ST_DRAIN);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any fill without fill_done.
  always_ff @(posedge adc_clk) begin
    if (reset_clk_adc) begin
      state_q        <= ST_IDLE;
      win_q          <= '0;
      holdoff_q      <= '0;
      raw_trig_dly_q <= 1'b0;
      acc_q          <= '0;
      drop_q         <= '0;
      wr_en_q        <= 1'b0;
      wr_dat_q       <= '0;
      trig_en_q      <= 1'b0;
      rd_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      close_q        <= '0;
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
      drain_cnt_q    <= '0;
      dto_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      win_q          <= win_d;
      holdoff_q      <= holdoff_d;
      raw_trig_dly_q <= raw_trig_dly_d;
      acc_q          <= acc_d;
      drop_q         <= drop_d;
      wr_en_q        <= wr_en_d;
      wr_dat_q       <= wr_dat_d;
      trig_en_q      <= trig_en_d;
      rd_en_q        <= rd_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      close_q        <= close_d;
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
      drain_cnt_q    <= drain_cnt_d;
      dto_q          <= dto_d;
`endif
    end
  end

  assign bus.cbuf_trig_en     = trig_en_q;
  assign bus.cbuf_rd_en       = rd_en_q;
  assign bus.trig_fifo_wr_en  = wr_en_q;
  assign bus.trig_fifo_wr_dat = wr_dat_q;
  assign bus.fill_busy        = busy_q;
  assign bus.fill_done        = done_q;
  assign bus.accepted_count   = acc_q;
  assign bus.dropped_count    = drop_q;
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
  assign bus.drain_timeout    = dto_q;
`endif
endmodule

// File: tb/tb_async_fill_trig_scheduler.sv
// Self-checking bench for async_fill_trig_scheduler: expected FIFO write
// addresses are queued when an accepted edge is driven and popped by a
// monitor when the DUT writes. Build with ASYNC_SCHED_DRAIN_TIMEOUT_EN to
// also exercise the drain timeout.
module tb_async_fill_trig_scheduler;
`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
  localparam int unsigned DT = 8;
`else
  localparam int unsigned DT = 65535;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  async_fill_trig_scheduler_if ifc ();

  async_fill_trig_scheduler #(.CLOSE_CYCLES(16), .DRAIN_TIMEOUT(DT)) dut (
    .adc_clk       (clk),
    .reset_clk_adc (rst),
    .bus           (ifc)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_q[$];
  int unsigned n_wr = 0, n_trig = 0, n_rd = 0, n_done = 0;
  int unsigned b_wr, b_trig, b_done, b_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: scoreboard pop on every FIFO write plus activity counters.
  always @(negedge clk) begin
    if (ifc.cbuf_trig_en === 1'b1) n_trig++;
    if (ifc.cbuf_rd_en === 1'b1)   n_rd++;
    if (ifc.fill_done === 1'b1)    n_done++;
    if (ifc.trig_fifo_wr_en === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else                   check("wr_dat", 32'(ifc.trig_fifo_wr_dat), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic start_fill(input logic [23:0] len, input logic [10:0] bursts, input logic [15:0] maxw);
    ifc.fill_window_len  = len;
    ifc.async_num_bursts = bursts;
    ifc.max_waveforms    = maxw;
    ifc.fill_start       = 1'b1;
    tick();
    ifc.fill_start       = 1'b0;
  endtask

  // One-cycle raw_trig pulse; push the address when the edge should be accepted.
  task automatic pulse(input logic [15:0] addr, input bit acc);
    ifc.raw_trig         = 1'b1;
    ifc.circ_buf_wr_addr = addr;
    if (acc) exp_q.push_back(addr);
    tick();
    ifc.raw_trig = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (ifc.fill_done !== 1'b1 && n < budget) begin
      tick();
      @(negedge clk);
      n++;
    end
    check(tag, 32'(ifc.fill_done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.fill_start = 1'b0; ifc.fill_window_len = '0; ifc.async_num_bursts = '0;
    ifc.max_waveforms = '0; ifc.raw_trig = 1'b0; ifc.circ_buf_wr_addr = '0;
    ifc.trig_fifo_full = 1'b0; ifc.trig_fifo_empty = 1'b1; ifc.cbuf_rd_trig_wait = 1'b1;
    idle(3);
    @(negedge clk);
    check("rst_busy", 32'(ifc.fill_busy), 0);
    check("rst_rd_en", 32'(ifc.cbuf_rd_en), 0);
    check("rst_acc", 32'(ifc.accepted_count), 0);
    rst = 1'b0;
    idle(2);

    // Reset mid-ARMED right after an accepted edge.
    start_fill(24'd100, 11'd3, 16'd0);
    idle(5);
    pulse(16'hBEEF, 1'b1);
    b_done = n_done;
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("abort_trig_en", 32'(ifc.cbuf_trig_en), 0);
    check("abort_rd_en", 32'(ifc.cbuf_rd_en), 0);
    check("abort_wr_en", 32'(ifc.trig_fifo_wr_en), 0);
    check("abort_wr_dat", 32'(ifc.trig_fifo_wr_dat), 0);
    check("abort_busy", 32'(ifc.fill_busy), 0);
    check("abort_acc", 32'(ifc.accepted_count), 0);
    check("abort_drop", 32'(ifc.dropped_count), 0);
    rst = 1'b0;
    idle(30);
    check("abort_no_done", n_done - b_done, 0);
    check("abort_idle", 32'(ifc.fill_busy), 0);

    // Single accepted trigger, 100-cycle window.
    b_trig = n_trig; b_wr = n_wr;
    start_fill(24'd100, 11'd3, 16'd0);
    idle(9);
    pulse(16'h1234, 1'b1);
    @(negedge clk);
    check("single_wr_en", 32'(ifc.trig_fifo_wr_en), 1);
    check("single_acc_now", 32'(ifc.accepted_count), 1);
    tick();
    @(negedge clk);
    check("single_wr_pulse", 32'(ifc.trig_fifo_wr_en), 0);
    check("single_dat_hold", 32'(ifc.trig_fifo_wr_dat), 32'h1234);
    wait_done("single_done", 300);
    check("single_trig_cycles", n_trig - b_trig, 100);
    check("single_writes", n_wr - b_wr, 1);
    check("single_acc", 32'(ifc.accepted_count), 1);
    check("single_drop", 32'(ifc.dropped_count), 0);
    idle(3);
    check("hold_acc_after_fill", 32'(ifc.accepted_count), 1);

    // Hold-off of 12 words: +12 rejected, +13 accepted.
    b_wr = n_wr;
    start_fill(24'd200, 11'd3, 16'd0);
    idle(2);
    pulse(16'h0100, 1'b1); idle(11);
    pulse(16'h0112, 1'b0); idle(11);
    pulse(16'h0124, 1'b1); idle(12);
    pulse(16'h0137, 1'b1);
    wait_done("holdoff_done", 400);
    check("holdoff_acc", 32'(ifc.accepted_count), 3);
    check("holdoff_drop", 32'(ifc.dropped_count), 1);
    check("holdoff_writes", n_wr - b_wr, 3);

    // Per-fill cap of 2 with 5 edges.
    b_wr = n_wr;
    start_fill(24'd200, 11'd1, 16'd2);
    for (int i = 0; i < 5; i++) begin
      idle(19);
      pulse(16'h2000 + 16'(i), i < 2);
    end
    wait_done("cap_done", 400);
    check("cap_acc", 32'(ifc.accepted_count), 2);
    check("cap_drop", 32'(ifc.dropped_count), 3);
    check("cap_writes", n_wr - b_wr, 2);

    // FIFO full: every edge rejected, counts restart from zero.
    b_wr = n_wr;
    ifc.trig_fifo_full = 1'b1;
    start_fill(24'd100, 11'd0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      idle(4);
      pulse(16'h3000 + 16'(i), 1'b0);
    end
    wait_done("full_done", 300);
    ifc.trig_fifo_full = 1'b0;
    check("full_acc", 32'(ifc.accepted_count), 0);
    check("full_drop", 32'(ifc.dropped_count), 3);
    check("full_writes", n_wr - b_wr, 0);

    // Drain held until FIFO empty and mover waiting.
    ifc.trig_fifo_empty = 1'b0; ifc.cbuf_rd_trig_wait = 1'b0;
    start_fill(24'd20, 11'd0, 16'd0);
    begin
      int unsigned n = 0;
      while (ifc.cbuf_trig_en === 1'b1 && n < 100) begin tick(); n++; end
      check("drain_window_end", 32'(ifc.cbuf_trig_en), 0);
    end
    idle(50);
    @(negedge clk);
    check("drain_rd_en_held", 32'(ifc.cbuf_rd_en), 1);
    check("drain_busy", 32'(ifc.fill_busy), 1);
    ifc.trig_fifo_empty = 1'b1; ifc.cbuf_rd_trig_wait = 1'b1;
    tick();
    @(negedge clk);
    check("drain_rd_en_fall", 32'(ifc.cbuf_rd_en), 0);
    begin
      int unsigned k = 0;
      while (ifc.fill_done !== 1'b1 && k < 40) begin tick(); @(negedge clk); k++; end
      check("close_len", k, 16);
    end
    tick();
    @(negedge clk);
    check("done_one_cycle", 32'(ifc.fill_done), 0);

    // Zero-length window skips ARMED.
    b_wr = n_wr; b_trig = n_trig;
    start_fill(24'd0, 11'd0, 16'd0);
    @(negedge clk);
    check("zero_trig_en", 32'(ifc.cbuf_trig_en), 0);
    check("zero_rd_en", 32'(ifc.cbuf_rd_en), 1);
    wait_done("zero_done", 100);
    check("zero_writes", n_wr - b_wr, 0);
    check("zero_trig_cycles", n_trig - b_trig, 0);

`ifdef ASYNC_SCHED_DRAIN_TIMEOUT_EN
    // Drain timeout with FIFO never empty.
    idle(2);
    ifc.trig_fifo_empty = 1'b0;
    b_rd = n_rd;
    start_fill(24'd0, 11'd0, 16'd0);
    @(negedge clk);
    check("dto_clear_before", 32'(ifc.drain_timeout), 0);
    wait_done("dto_done", 200);
    check("dto_rd_cycles", n_rd - b_rd, 8);
    check("dto_flag", 32'(ifc.drain_timeout), 1);
    ifc.trig_fifo_empty = 1'b1;
    idle(2);
    check("dto_sticky", 32'(ifc.drain_timeout), 1);
    start_fill(24'd5, 11'd0, 16'd0);
    @(negedge clk);
    check("dto_cleared", 32'(ifc.drain_timeout), 0);
    wait_done("dto_next_done", 100);
`endif

    idle(2);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
